// File: rtl/pkt_rd_pkg.sv
// Shared types and widths for the packet FIFO reader.
package pkt_rd_pkg;

    localparam int unsigned LEN_W  = 11;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StStream,
        StGap
    } state_e;

    // A zero-length gap still needs one cycle to emit pkt_done.
    function automatic int unsigned gap_cycles(input int unsigned gap);
        return (gap == 0) ? 1 : gap;
    endfunction

endpackage

// File: rtl/pkt_fifo_reader_if.sv
// FIFO-side and stream-side signals of the packet reader, grouped for port passing.
interface pkt_fifo_reader_if;
    import pkt_rd_pkg::*;

    logic              en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic [LEN_W-1:0]  fifo_rd_level;
    logic              fifo_rd_en;
    logic              pkt_start;
    logic [LEN_W-1:0]  pkt_len;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              pkt_done;
    logic              busy;

    modport master (
        input  en, fifo_rd_data, fifo_empty, fifo_rd_level, out_ready,
        output fifo_rd_en, pkt_start, pkt_len, out_data, out_valid, out_last, pkt_done, busy
    );

    modport slave (
        output en, fifo_rd_data, fifo_empty, fifo_rd_level, out_ready,
        input  fifo_rd_en, pkt_start, pkt_len, out_data, out_valid, out_last, pkt_done, busy
    );

endinterface

// File: rtl/pkt_skid_buf.sv
// Two-entry FIFO-order buffer between the byte FIFO read port and the output stream.
module pkt_skid_buf
    import pkt_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_occ;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new byte lands behind the head.
                    if (r_occ == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/pkt_fifo_reader.sv
// Releases fixed-length packets from an upstream byte FIFO onto a valid/ready stream,
// separated by a programmable idle gap.
module pkt_fifo_reader
    import pkt_rd_pkg::*;
#(
    parameter int unsigned PKT_LEN = 64,
    parameter int unsigned GAP_CYC = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    pkt_fifo_reader_if.master  bus
);

    localparam logic [LEN_W-1:0] LEN_V    = LEN_W'(PKT_LEN);
    localparam logic [LEN_W-1:0] LAST_V   = LEN_W'(PKT_LEN - 1);
    localparam logic [7:0]       GAP_LAST = 8'(gap_cycles(GAP_CYC) - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [LEN_W-1:0]  r_rd_cnt;
    logic [LEN_W-1:0]  r_tx_cnt;
    logic              r_rd_pend;
    logic [7:0]        r_gap_cnt;

    logic [DATA_W-1:0] w_head;
    logic [1:0]        w_occ;
    logic              w_valid;
    logic              w_pop;
    logic              w_room;
    logic              w_rd_en;
    logic              w_last_pop;

    assign w_valid    = (w_occ != 2'd0);
    assign w_pop      = w_valid && bus.out_ready;
    // A read is safe only if the byte it returns will still find a free slot.
    assign w_room     = ({1'b0, w_occ} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop});
    assign w_rd_en    = (r_state == StStream) && (r_rd_cnt < LEN_V) && !bus.fifo_empty && w_room;
    assign w_last_pop = w_pop && (r_tx_cnt == LAST_V);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (bus.en && (bus.fifo_rd_level >= LEN_V)) w_state_nxt = StStart;
            StStart:  w_state_nxt = StStream;
            StStream: if (w_last_pop) w_state_nxt = StGap;
            StGap:    if (r_gap_cnt == GAP_LAST) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_rd_cnt  <= '0;
            r_tx_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_rd_en;
            if (r_state == StStart) begin
                r_rd_cnt <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_rd_en) r_rd_cnt <= r_rd_cnt + 11'd1;
                if (w_pop)   r_tx_cnt <= r_tx_cnt + 11'd1;
            end
            if (r_state == StGap) r_gap_cnt <= r_gap_cnt + 8'd1;
            else                  r_gap_cnt <= '0;
        end
    end

    pkt_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_rd_pend),
        .i_data (bus.fifo_rd_data),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_occ  (w_occ)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.pkt_start  = (r_state == StStart);
    assign bus.pkt_len    = (r_state == StStart) ? LEN_V : '0;
    assign bus.out_data   = w_head;
    assign bus.out_valid  = w_valid;
    assign bus.out_last   = w_valid && (r_tx_cnt == LAST_V);
    assign bus.pkt_done   = (r_state == StGap) && (r_gap_cnt == 8'd0);
    assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Randomised and directed bench for pkt_fifo_reader against a packet-level reference model.
module tb_pkt_fifo_reader;
    import pkt_rd_pkg::*;

    localparam int unsigned PL     = 64;
    localparam int unsigned GAP    = 12;
    localparam int unsigned GAPMIN = (GAP == 0) ? 1 : GAP;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pkt_fifo_reader_if b0 ();
    pkt_fifo_reader_if b1 ();

    pkt_fifo_reader #(.PKT_LEN(PL), .GAP_CYC(GAP)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    pkt_fifo_reader #(.PKT_LEN(1), .GAP_CYC(0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Upstream FIFO contents and the in-order record of every byte ever pushed.
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] sb[$];

    // ---------------- reference model / compare process ----------------
    int   cyc = 0;
    int   sb_rd = 0;
    int   m_idx = 0;
    int   m_idle_at = 0;
    bit   m_busy = 0, m_gap = 0, m_start_nxt = 0, m_done_nxt = 0, m_stall = 0;
    logic [7:0] m_hold = '0;

    always @(negedge clk) begin
        bit e_start, e_done;
        if (!rst_n) begin
            check("rst_rd_en", b0.fifo_rd_en, 0);
            check("rst_pkt_start", b0.pkt_start, 0);
            check("rst_out_valid", b0.out_valid, 0);
            check("rst_out_last", b0.out_last, 0);
            check("rst_pkt_done", b0.pkt_done, 0);
            check("rst_busy", b0.busy, 0);
            check("rst_pkt_len", b0.pkt_len, 0);
            check("rst_out_data", b0.out_data, 0);
            m_busy = 0; m_gap = 0; m_start_nxt = 0; m_done_nxt = 0;
            m_idx = 0; m_stall = 0; sb_rd = sb.size();
        end else begin
            if (m_gap && cyc >= m_idle_at) begin
                m_gap  = 0;
                m_busy = 0;
            end
            e_start = m_start_nxt;
            e_done  = m_done_nxt;
            m_start_nxt = 0;
            m_done_nxt  = 0;
            check("busy", b0.busy, m_busy);
            check("pkt_start", b0.pkt_start, e_start);
            if (e_start) check("pkt_len", b0.pkt_len, PL);
            check("pkt_done", b0.pkt_done, e_done);
            check("out_last", b0.out_last, b0.out_valid && (m_idx == PL - 1));
            if (!m_busy) check("rd_en_idle", b0.fifo_rd_en, 0);
            if (b0.fifo_rd_en) check("rd_when_empty", b0.fifo_empty, 0);
            if (m_stall) begin
                check("hold_valid", b0.out_valid, 1);
                check("hold_data", b0.out_data, m_hold);
            end
            if (b0.out_valid && b0.out_ready) begin
                if (!m_busy) check("xfer_when_idle", 1, 0);
                if (sb_rd >= sb.size()) check("extra_byte", sb_rd, sb.size());
                else check("data", b0.out_data, sb[sb_rd]);
                sb_rd++;
                m_idx++;
                if (m_idx == PL) begin
                    m_idx = 0;
                    m_done_nxt = 1;
                end
            end
            m_stall = b0.out_valid && !b0.out_ready;
            m_hold  = b0.out_data;
            if (e_done) begin
                m_gap = 1;
                m_idle_at = cyc + GAPMIN;
            end
            if (!m_busy && b0.en && (b0.fifo_rd_level >= PL)) begin
                m_busy = 1;
                m_start_nxt = 1;
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    int dcyc = 0, n_start = 0, n_done = 0, n_xfer = 0;
    int last_start = 0, last_done = 0, rdy_mode = 0, rdy_ph = 0;
    logic [7:0] last_byte = '0;
    logic [7:0] x_bytes[$];
    int   s_start[$], s_done[$], s_xcyc[$];
    logic [7:0] s_bytes[$];
    bit   s_lasts[$];

    task automatic upd_levels();
        b0.fifo_rd_level = 11'(fq0.size());
        b0.fifo_empty    = (fq0.size() == 0);
        b1.fifo_rd_level = 11'(fq1.size());
        b1.fifo_empty    = (fq1.size() == 0);
    endtask

    task automatic push0(input logic [7:0] v);
        fq0.push_back(v);
        sb.push_back(v);
        upd_levels();
    endtask

    task automatic push1(input logic [7:0] v);
        fq1.push_back(v);
        upd_levels();
    endtask

    task automatic step();
        logic rd0, rd1;
        @(negedge clk);
        rd0 = b0.fifo_rd_en;
        rd1 = b1.fifo_rd_en;
        if (rst_n) begin
            if (b0.pkt_start) begin n_start++; last_start = dcyc; end
            if (b0.pkt_done) begin n_done++; last_done = dcyc; end
            if (b0.out_valid && b0.out_ready) begin
                n_xfer++;
                x_bytes.push_back(b0.out_data);
                if (b0.out_last) last_byte = b0.out_data;
            end
            if (b1.pkt_start) s_start.push_back(dcyc);
            if (b1.pkt_done) s_done.push_back(dcyc);
            if (b1.out_valid && b1.out_ready) begin
                s_bytes.push_back(b1.out_data);
                s_lasts.push_back(b1.out_last);
                s_xcyc.push_back(dcyc);
            end
        end
        @(posedge clk);
        #1;
        dcyc++;
        if (rd0 && fq0.size() > 0) b0.fifo_rd_data = fq0.pop_front();
        if (rd1 && fq1.size() > 0) b1.fifo_rd_data = fq1.pop_front();
        case (rdy_mode)
            0: b0.out_ready = 1'b1;
            1: begin
                b0.out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
                rdy_ph++;
            end
            default: b0.out_ready = 1'($urandom_range(0, 1));
        endcase
        upd_levels();
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (n_done < target && n < budget) begin step(); n++; end
        if (n_done < target) check(name, n_done, target);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n = 0;
        while (n_start < target && n < budget) begin step(); n++; end
        if (n_start < target) check(name, n_start, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int p, base, xb, bx, d1, nd, n;
        b0.en = 0; b0.fifo_rd_data = '0; b0.out_ready = 1;
        b1.en = 0; b1.fifo_rd_data = '0; b1.out_ready = 1;
        upd_levels();
        #1 rst_n = 0;
        repeat (3) step();
        check("reset_busy", b0.busy, 0);
        check("reset_out_valid", b0.out_valid, 0);
        rst_n = 1;
        repeat (2) step();

        // PKT_LEN=1, GAP_CYC=0 instance: two single-byte packets back to back.
        b1.en = 1;
        p = dcyc;
        push1(8'hA5);
        push1(8'h5A);
        n = 0;
        while (s_done.size() < 2 && n < 40) begin step(); n++; end
        check("s_dones", s_done.size(), 2);
        if (s_done.size() == 2 && s_start.size() == 2 && s_bytes.size() == 2) begin
            check("s_start1", s_start[0], p + 1);
            check("s_xfer1", s_xcyc[0], p + 4);
            check("s_data1", s_bytes[0], 8'hA5);
            check("s_last1", s_lasts[0], 1);
            check("s_done1", s_done[0], p + 5);
            check("s_start2", s_start[1], s_done[0] + 2);
            check("s_data2", s_bytes[1], 8'h5A);
            check("s_last2", s_lasts[1], 1);
            check("s_done2", s_done[1], s_start[1] + 4);
        end
        check("s_bytes", s_bytes.size(), 2);

        // Preloaded 0x00..0x3F with ready held high.
        rdy_mode = 0;
        base = n_start;
        xb = x_bytes.size();
        for (int i = 0; i < 64; i++) push0(8'(i));
        b0.en = 1;
        wait_dones(n_done + 1, 200, "p38_timeout");
        check("p38_starts", n_start - base, 1);
        check("p38_span", last_done - last_start, 67);
        check("p38_count", x_bytes.size() - xb, 64);
        if (x_bytes.size() >= xb + 64) begin
            check("p38_first", x_bytes[xb], 8'h00);
            check("p38_63", x_bytes[xb + 63], 8'h3F);
        end
        check("p38_last_byte", last_byte, 8'h3F);

        // 63 bytes must not release a packet; the 64th does on the next cycle.
        repeat (GAPMIN + 2) step();
        base = n_start;
        for (int i = 0; i < 63; i++) push0(8'(8'h40 + i));
        repeat (20) step();
        check("p39_idle", n_start - base, 0);
        push0(8'h7F);
        p = dcyc;
        wait_starts(base + 1, 10, "p39_timeout");
        check("p39_start_cyc", last_start, p + 1);
        wait_dones(n_done + 1, 200, "p39_done_timeout");

        // Ready pattern 1,0,0,1.
        repeat (GAPMIN + 2) step();
        rdy_mode = 1;
        rdy_ph = 0;
        bx = n_xfer;
        for (int i = 0; i < 64; i++) push0(8'($urandom));
        wait_dones(n_done + 1, 600, "p40_timeout");
        check("p40_count", n_xfer - bx, 64);

        // Two back-to-back packets, gap timing.
        rdy_mode = 0;
        repeat (GAPMIN + 2) step();
        nd = n_done;
        base = n_start;
        for (int i = 0; i < 128; i++) push0(8'($urandom));
        wait_dones(nd + 1, 300, "p41_done1");
        d1 = last_done;
        wait_starts(base + 2, 100, "p41_start2");
        check("p41_gap", last_start - d1, 13);
        wait_dones(nd + 2, 300, "p41_done2");

        // Random ready, random en, trickling pushes.
        rdy_mode = 2;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 2) == 0 && fq0.size() < 900) begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) push0(8'($urandom));
            end
            b0.en = ($urandom_range(0, 3) != 0);
            step();
        end
        b0.en = 1;
        rdy_mode = 0;
        n = 0;
        while ((fq0.size() >= PL || b0.busy) && n < 3000) begin step(); n++; end
        check("rand_drain", b0.busy, 0);

        // Reset after 20 transferred bytes, then a clean packet.
        bx = n_xfer;
        for (int i = 0; i < 64; i++) push0(8'(8'h80 + i));
        n = 0;
        while (n_xfer - bx < 20 && n < 300) begin step(); n++; end
        check("p42_reach20", n_xfer - bx >= 20, 1);
        rst_n = 0;
        fq0.delete();
        upd_levels();
        #1;
        check("p42_rd_en", b0.fifo_rd_en, 0);
        check("p42_start", b0.pkt_start, 0);
        check("p42_valid", b0.out_valid, 0);
        check("p42_last", b0.out_last, 0);
        check("p42_done", b0.pkt_done, 0);
        check("p42_busy", b0.busy, 0);
        check("p42_len", b0.pkt_len, 0);
        check("p42_data", b0.out_data, 0);
        repeat (2) step();
        rst_n = 1;
        bx = n_xfer;
        base = n_start;
        nd = n_done;
        for (int i = 0; i < 64; i++) push0(8'($urandom));
        wait_dones(nd + 1, 300, "p42_timeout");
        check("p42_starts", n_start - base, 1);
        check("p42_count", n_xfer - bx, 64);

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_fifo_reader.md
PKT_FIFO_READER -- requirements
Module: pkt_fifo_reader

Interface
REQ-001 Parameter PKT_LEN, default 64, SHALL set the packet length in bytes; legal range 1..1024.
REQ-002 Parameter GAP_CYC, default 12, SHALL set the idle cycles between packets; legal range 0..255.
REQ-003 clk  input  1  single clock for all logic; also the read clock of the upstream byte FIFO.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  high = packet release allowed; sampled only in IDLE.
REQ-006 fifo_rd_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_rd_level  input  11  FIFO read-side fill level in bytes (0..1024).
REQ-009 fifo_rd_en  output  1  FIFO read strobe.
REQ-010 pkt_start  output  1  one-cycle pulse announcing a packet.
REQ-011 pkt_len  output  11  equals PKT_LEN; valid while pkt_start is high.
REQ-012 out_data  output  8  stream byte.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts; a byte transfers when out_valid and out_ready are both high.
REQ-015 out_last  output  1  marks the final byte of a packet; qualified by out_valid.
REQ-016 pkt_done  output  1  one-cycle pulse after the last-byte transfer.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, START, STREAM, GAP.
REQ-019 IDLE -> START SHALL occur when en=1 and fifo_rd_level >= PKT_LEN; otherwise the FSM stays in IDLE.
REQ-020 START SHALL last exactly one cycle, with pkt_start=1 in that cycle, then go to STREAM.
REQ-021 In STREAM, an 11-bit counter rd_cnt SHALL count issued reads from 0; reads SHALL stop when rd_cnt=PKT_LEN.
REQ-022 Read data SHALL enter a 2-entry FIFO-order buffer; out_valid = occupancy>0; out_data = head entry.
REQ-023 fifo_rd_en SHALL be high only when all of the following hold: state=STREAM, rd_cnt<PKT_LEN, fifo_empty=0, and (occupancy + outstanding read - pop) < 2; pop = out_valid & out_ready.
REQ-024 On STREAM entry at cycle 0: fifo_rd_en=1 in cycle 0, and out_valid=1 from cycle 2 onward.
REQ-025 With out_ready held high, throughput SHALL be 1 byte/clk with no bubbles.
REQ-026 out_data SHALL hold its value while out_valid=1 and out_ready=0; the buffer SHALL never overflow or drop a byte.
REQ-027 fifo_empty=1 during STREAM SHALL stall reads only; bytes already buffered still drain; no error is raised.
REQ-028 An 11-bit counter tx_cnt SHALL count popped bytes; out_last=1 exactly when tx_cnt=PKT_LEN-1 and out_valid=1.
REQ-029 The pop of the last byte SHALL move the FSM to GAP, with pkt_done=1 in the first GAP cycle.
REQ-030 GAP SHALL last max(GAP_CYC,1) cycles, then return to IDLE; pkt_done pulses even when GAP_CYC=0.
REQ-031 en is ignored outside IDLE; deasserting it mid-packet SHALL NOT truncate the packet.
REQ-032 Total bytes emitted per packet SHALL equal PKT_LEN exactly, including when PKT_LEN=1 (out_last on the first byte).

Reset
REQ-033 rst_n low SHALL immediately force IDLE, clear both counters, clear buffer occupancy, and clear the outstanding-read flag.
REQ-034 During reset, fifo_rd_en, pkt_start, out_valid, out_last, pkt_done and busy SHALL be 0; pkt_len and out_data SHALL be 0.
REQ-035 Reset mid-packet SHALL discard the partial packet; bytes of the partial packet left in the FIFO are not reclaimed.

Structure
REQ-036 Package pkt_rd_pkg SHALL hold the state enumeration, LEN_W=11, and DATA_W=8.
REQ-037 The 2-entry buffer SHALL be a sub-module pkt_skid_buf (push, pop, data, occupancy), instantiated once.

Verification
REQ-038 Preload 64 bytes 0x00..0x3F, en=1, out_ready=1 -> one pkt_start pulse; then 64 consecutive bytes 0x00..0x3F; out_last on 0x3F; pkt_done one cycle later.
REQ-039 fifo_rd_level=63 with PKT_LEN=64 -> FSM stays in IDLE and fifo_rd_en stays 0; level reaching 64 -> START on the next cycle.
REQ-040 out_ready toggling 1,0,0,1 per cycle -> no byte lost or duplicated; occupancy <= 2; data stable while stalled.
REQ-041 Preload 128 bytes, GAP_CYC=12 -> two packets; pkt_start of the second packet occurs exactly 13 cycles after the first pkt_done.
REQ-042 rst_n low after 20 bytes transferred -> all outputs 0 that cycle; after release, with 64 bytes buffered, the next packet starts cleanly.
REQ-043 PKT_LEN=1, one byte preloaded -> pkt_start, then a single byte with out_last=1, then pkt_done.
